// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Captures the Memory-stage control/data into the W register. Applies load
// extension to the raw DM word and selects the register-file write data.
// All outputs are driven from the W register only. No M-to-W combinational path.
// Optional: define WB_TRACE_EN to print a writeback trace line per GRF write.
// Only DW = 32 is supported; the load-extension slices assume a 32-bit word.
module mem_wb_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic          RegWriteM2,
  input  logic [1:0]    MemtoRegM2,
  input  logic [2:0]    LoadopM2,
  input  logic [DW-1:0] RDM,
  input  logic [DW-1:0] ALUoutM2,
  input  logic [DW-1:0] PC_4M2,
  input  logic [1:0]    TnewM2,
  input  logic [AW-1:0] AwriteM2,
  output logic          RegWriteW,
  output logic [AW-1:0] AwriteW,
  output logic [DW-1:0] ResultW,
  output logic [1:0]    TnewW,
  output logic [DW-1:0] PC_4W
);

  // Result-select encodings
  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelLink = 2'b10;

  // Load-type encodings; anything else behaves as lw
  localparam logic [2:0] LdWord = 3'b000;
  localparam logic [2:0] LdBu   = 3'b001;
  localparam logic [2:0] LdB    = 3'b010;
  localparam logic [2:0] LdHu   = 3'b011;
  localparam logic [2:0] LdH    = 3'b100;

  // W register fields
  logic          regWriteQ;
  logic [1:0]    memtoRegQ;
  logic [2:0]    loadopQ;
  logic [DW-1:0] rdQ;
  logic [DW-1:0] aluOutQ;
  logic [DW-1:0] pc4Q;
  logic [1:0]    tnewQ;
  logic [AW-1:0] awriteQ;

  logic [1:0]    tnewDec;
  logic [1:0]    byteAddr;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [DW-1:0] loadData;
  logic          writeValid;

  // Tnew counts down by one per stage, saturating at zero
  always_comb begin
    tnewDec = 2'd0;
    if (TnewM2 != 2'd0) begin
      tnewDec = TnewM2 - 2'd1;
    end
  end

  // W register: async reset, then flush, then hold, then capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWriteQ <= 1'b0;
      memtoRegQ <= 2'b00;
      loadopQ   <= 3'b000;
      rdQ       <= '0;
      aluOutQ   <= '0;
      pc4Q      <= '0;
      tnewQ     <= 2'd0;
      awriteQ   <= '0;
    end else if (flush) begin
      regWriteQ <= 1'b0;
      memtoRegQ <= 2'b00;
      loadopQ   <= 3'b000;
      rdQ       <= '0;
      aluOutQ   <= '0;
      pc4Q      <= '0;
      tnewQ     <= 2'd0;
      awriteQ   <= '0;
    end else if (en) begin
      regWriteQ <= RegWriteM2;
      memtoRegQ <= MemtoRegM2;
      loadopQ   <= LoadopM2;
      rdQ       <= RDM;
      aluOutQ   <= ALUoutM2;
      pc4Q      <= PC_4M2;
      tnewQ     <= tnewDec;
      awriteQ   <= AwriteM2;
    end
  end

  // Little-endian byte and halfword lane selection from the stored address
  always_comb begin
    byteAddr = aluOutQ[1:0];
    byteSel  = rdQ[7:0];
    unique case (byteAddr)
      2'd0: byteSel = rdQ[7:0];
      2'd1: byteSel = rdQ[15:8];
      2'd2: byteSel = rdQ[23:16];
      2'd3: byteSel = rdQ[31:24];
      default: byteSel = rdQ[7:0];
    endcase
    halfSel = byteAddr[1] ? rdQ[31:16] : rdQ[15:0];
  end

  // Load extension; lw ignores the address and no alignment check is made
  always_comb begin
    loadData = rdQ;
    case (loadopQ)
      LdWord:  loadData = rdQ;
      LdBu:    loadData = {24'h000000, byteSel};
      LdB:     loadData = {{24{byteSel[7]}}, byteSel};
      LdHu:    loadData = {16'h0000, halfSel};
      LdH:     loadData = {{16{halfSel[15]}}, halfSel};
      default: loadData = rdQ;
    endcase
  end

  // Writeback data select; link address is PC+8, wrapping at 32 bits
  always_comb begin
    ResultW = aluOutQ;
    case (memtoRegQ)
      SelAlu:  ResultW = aluOutQ;
      SelLoad: ResultW = loadData;
      SelLink: ResultW = pc4Q + DW'(4);
      default: ResultW = aluOutQ;
    endcase
  end

  // A write to $0 is suppressed here so downstream forwarding never sees it
  always_comb begin
    writeValid = regWriteQ && (awriteQ != '0);
    RegWriteW  = writeValid;
    AwriteW    = writeValid ? awriteQ : '0;
    TnewW      = tnewQ;
    PC_4W      = pc4Q;
  end

`ifdef WB_TRACE_EN
  // Simulation trace of every architectural register write
  always @(posedge clk) begin
    if (reset && RegWriteW) begin
      $display("@%h: $%d <= %h", PC_4W - DW'(4), AwriteW, ResultW);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// reset/stall/flush sequences and randomized traffic against a reference model.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        regWrite;
    logic [1:0]  memtoReg;
    logic [2:0]  loadop;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [1:0]  tnew;
    logic [4:0]  awrite;
  } mIn_t;

  typedef struct packed {
    logic        regWrite;
    logic [4:0]  awrite;
    logic [31:0] result;
    logic [1:0]  tnew;
    logic [31:0] pc4;
  } wOut_t;

  typedef struct {
    mIn_t        in;
    logic [31:0] expResult;
    logic        expRw;
    logic [4:0]  expAw;
    logic [1:0]  expTnew;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        flush = 1'b0;
  logic        RegWriteM2 = 1'b0;
  logic [1:0]  MemtoRegM2 = 2'b00;
  logic [2:0]  LoadopM2 = 3'b000;
  logic [31:0] RDM = '0;
  logic [31:0] ALUoutM2 = '0;
  logic [31:0] PC_4M2 = '0;
  logic [1:0]  TnewM2 = 2'd0;
  logic [4:0]  AwriteM2 = '0;
  logic        RegWriteW;
  logic [4:0]  AwriteW;
  logic [31:0] ResultW;
  logic [1:0]  TnewW;
  logic [31:0] PC_4W;

  int checks = 0;
  int errors = 0;
  mIn_t  curIn = '0;
  wOut_t cur = '0;
  vec_t  vecs[$];

  mem_wb_stage #(.DW(32), .AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .flush      (flush),
    .RegWriteM2 (RegWriteM2),
    .MemtoRegM2 (MemtoRegM2),
    .LoadopM2   (LoadopM2),
    .RDM        (RDM),
    .ALUoutM2   (ALUoutM2),
    .PC_4M2     (PC_4M2),
    .TnewM2     (TnewM2),
    .AwriteM2   (AwriteM2),
    .RegWriteW  (RegWriteW),
    .AwriteW    (AwriteW),
    .ResultW    (ResultW),
    .TnewW      (TnewW),
    .PC_4W      (PC_4W)
  );

  always #5 clk = ~clk;

  // Reference: what the W stage should present after capturing m
  function automatic wOut_t wbModel(input mIn_t m);
    wOut_t o;
    int unsigned a;
    logic [31:0] b, h, ld;
    a  = m.alu % 4;
    b  = (m.rd >> (8 * a)) & 32'hFF;
    h  = (a >= 2) ? (m.rd >> 16) : (m.rd & 32'hFFFF);
    case (m.loadop)
      3'd1:    ld = b;
      3'd2:    ld = (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd3:    ld = h;
      3'd4:    ld = (h >= 32768) ? h + 32'hFFFF0000 : h;
      default: ld = m.rd;
    endcase
    case (m.memtoReg)
      2'd1:    o.result = ld;
      2'd2:    o.result = m.pc4 + 32'd4;
      default: o.result = m.alu;
    endcase
    o.regWrite = m.regWrite && (m.awrite != 5'd0);
    o.awrite   = o.regWrite ? m.awrite : 5'd0;
    o.tnew     = (m.tnew == 2'd0) ? 2'd0 : m.tnew - 2'd1;
    o.pc4      = m.pc4;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkAll(input string tag, input wOut_t e);
    chk({tag, " RegWriteW"}, {31'b0, RegWriteW}, {31'b0, e.regWrite});
    chk({tag, " AwriteW"}, {27'b0, AwriteW}, {27'b0, e.awrite});
    chk({tag, " ResultW"}, ResultW, e.result);
    chk({tag, " TnewW"}, {30'b0, TnewW}, {30'b0, e.tnew});
    chk({tag, " PC_4W"}, PC_4W, e.pc4);
  endtask

  task automatic drive(input mIn_t m);
    curIn      = m;
    RegWriteM2 = m.regWrite;
    MemtoRegM2 = m.memtoReg;
    LoadopM2   = m.loadop;
    RDM        = m.rd;
    ALUoutM2   = m.alu;
    PC_4M2     = m.pc4;
    TnewM2     = m.tnew;
    AwriteM2   = m.awrite;
  endtask

  // One clock with the given en/flush, then compare against the model
  task automatic step(input string tag, input logic enV, input logic flushV);
    wOut_t nxt;
    en    = enV;
    flush = flushV;
    if (flushV)   nxt = '0;
    else if (enV) nxt = wbModel(curIn);
    else          nxt = cur;
    @(posedge clk);
    #1;
    cur = nxt;
    chkAll(tag, cur);
  endtask

  function automatic mIn_t mk(input logic rw, input logic [1:0] mtr, input logic [2:0] lop,
                              input logic [31:0] rd, input logic [31:0] alu,
                              input logic [31:0] pc4, input logic [1:0] tn,
                              input logic [4:0] aw);
    mIn_t m;
    m.regWrite = rw; m.memtoReg = mtr; m.loadop = lop; m.rd = rd;
    m.alu = alu; m.pc4 = pc4; m.tnew = tn; m.awrite = aw;
    return m;
  endfunction

  task automatic addVec(input mIn_t m, input logic [31:0] res, input logic rw,
                        input logic [4:0] aw, input logic [1:0] tn);
    vec_t v;
    v.in = m; v.expResult = res; v.expRw = rw; v.expAw = aw; v.expTnew = tn;
    vecs.push_back(v);
  endtask

  function automatic mIn_t rndIn();
    mIn_t m;
    m.regWrite = 1'($urandom_range(0, 1));
    m.memtoReg = 2'($urandom_range(0, 3));
    m.loadop   = 3'($urandom_range(0, 7));
    m.rd       = $urandom;
    m.alu      = $urandom;
    m.pc4      = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
    m.tnew     = 2'($urandom_range(0, 3));
    m.awrite   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return m;
  endfunction

  localparam logic [31:0] Rd = 32'h80FF7F01;

  initial begin
    wOut_t zero = '0;
    // Directed vectors: {inputs} -> {ResultW, RegWriteW, AwriteW, TnewW}
    addVec(mk(1, 2'd1, 3'd2, Rd, 32'h101, 32'h1000, 2'd2, 5'd8),  32'h0000007F, 1, 5'd8,  2'd1);
    addVec(mk(1, 2'd1, 3'd2, Rd, 32'h103, 32'h1004, 2'd0, 5'd9),  32'hFFFFFF80, 1, 5'd9,  2'd0);
    addVec(mk(1, 2'd1, 3'd1, Rd, 32'h103, 32'h1008, 2'd1, 5'd10), 32'h00000080, 1, 5'd10, 2'd0);
    addVec(mk(1, 2'd1, 3'd4, Rd, 32'h102, 32'h100C, 2'd3, 5'd11), 32'hFFFF80FF, 1, 5'd11, 2'd2);
    addVec(mk(1, 2'd1, 3'd3, Rd, 32'h100, 32'h1010, 2'd2, 5'd12), 32'h00007F01, 1, 5'd12, 2'd1);
    addVec(mk(1, 2'd1, 3'd3, Rd, 32'h102, 32'h1014, 2'd0, 5'd13), 32'h000080FF, 1, 5'd13, 2'd0);
    addVec(mk(1, 2'd1, 3'd1, Rd, 32'h102, 32'h1018, 2'd0, 5'd14), 32'h000000FF, 1, 5'd14, 2'd0);
    addVec(mk(1, 2'd1, 3'd0, Rd, 32'h102, 32'h101C, 2'd0, 5'd15), 32'h80FF7F01, 1, 5'd15, 2'd0);
    addVec(mk(1, 2'd1, 3'd5, Rd, 32'h101, 32'h1020, 2'd0, 5'd16), 32'h80FF7F01, 1, 5'd16, 2'd0);
    addVec(mk(1, 2'd2, 3'd0, Rd, 32'h0, 32'h00003010, 2'd0, 5'd31), 32'h00003014, 1, 5'd31, 2'd0);
    addVec(mk(1, 2'd2, 3'd0, Rd, 32'h0, 32'hFFFFFFFC, 2'd0, 5'd31), 32'h00000000, 1, 5'd31, 2'd0);
    addVec(mk(1, 2'd0, 3'd1, Rd, 32'h12345678, 32'h1024, 2'd1, 5'd3), 32'h12345678, 1, 5'd3, 2'd0);
    addVec(mk(1, 2'd3, 3'd1, Rd, 32'hDEADBEEF, 32'h1028, 2'd2, 5'd4), 32'hDEADBEEF, 1, 5'd4, 2'd1);
    addVec(mk(1, 2'd0, 3'd0, Rd, 32'h00000005, 32'h102C, 2'd0, 5'd0), 32'h00000005, 0, 5'd0, 2'd0);
    addVec(mk(0, 2'd0, 3'd0, Rd, 32'h00000006, 32'h1030, 2'd2, 5'd7), 32'h00000006, 0, 5'd0, 2'd1);

    // Reset state at time 1, reset released away from a clock edge
    #1;
    chkAll("reset", zero);
    #12;
    reset = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].in);
      step(tag, 1'b1, 1'b0);
      chk({tag, " tbl ResultW"}, ResultW, vecs[i].expResult);
      chk({tag, " tbl RegWriteW"}, {31'b0, RegWriteW}, {31'b0, vecs[i].expRw});
      chk({tag, " tbl AwriteW"}, {27'b0, AwriteW}, {27'b0, vecs[i].expAw});
      chk({tag, " tbl TnewW"}, {30'b0, TnewW}, {30'b0, vecs[i].expTnew});
    end

    // Mid-cycle async reset after a capture; release mid-cycle without capture
    drive(vecs[0].in);
    step("pre-reset", 1'b1, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    cur = '0;
    chkAll("async reset", zero);
    drive(vecs[9].in);
    #2;
    reset = 1'b1;
    #1;
    chkAll("after release", zero);
    step("first capture", 1'b1, 1'b0);
    chk("first capture ResultW", ResultW, 32'h00003014);

    // Stall three cycles, then flush during stall, then resume
    drive(vecs[3].in);
    step("pre-stall", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(rndIn());
      step($sformatf("stall%0d", i), 1'b0, 1'b0);
      chk($sformatf("stall%0d frozen ResultW", i), ResultW, 32'hFFFF80FF);
    end
    drive(vecs[4].in);
    step("flush+stall", 1'b0, 1'b1);
    chkAll("flush bubble", zero);
    drive(vecs[11].in);
    step("resume", 1'b1, 1'b0);
    chk("resume ResultW", ResultW, 32'h12345678);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(rndIn());
      step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the P6 five-stage MIPS pipeline; sits directly downstream of the Memory stage and consumes its outputs.
- Registers the M-stage control and data. Applies the load-type extension to the raw DM word. Selects the register-file write data.
- Produces ResultW, RegWriteW, AwriteW and TnewW. The Memory stage forwarding mux and the hazard unit use these.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- AW, 5, register-address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; 0 holds the W register (stall).
- flush  input  1  synchronous bubble insert into W.
- RegWriteM2  input  1  register write request from M.
- MemtoRegM2  input  2  result select: 00 ALUout, 01 load data, 10 PC+8, 11 ALUout.
- LoadopM2  input  3  load type: 000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh, others treated as lw.
- RDM  input  32  raw word read from DM.
- ALUoutM2  input  32  ALU result / memory address.
- PC_4M2  input  32  PC+4 of the M instruction.
- TnewM2  input  2  cycles until the result is ready, as seen in M.
- AwriteM2  input  5  destination register.
- RegWriteW  output  1  GRF write enable.
- AwriteW  output  5  GRF write address.
- ResultW  output  32  GRF write data; also the forwarding source.
- TnewW  output  2  Tnew remaining in W.
- PC_4W  output  32  PC+4 of the W instruction, used for trace and debug.

Behaviour:
- W register holds RegWrite, MemtoReg, Loadop, RD, ALUout, PC_4, Tnew and Awrite, updated on posedge clk.
- Update priority per edge: reset low (async) > flush > en==0 (hold) > capture.
- Reset or flush value: all register fields 0. The resulting outputs are RegWriteW=0, AwriteW=0, TnewW=0, PC_4W=0 and ResultW=0.
- Reset acts immediately on assertion, mid-cycle, regardless of en or flush.
- Capture stores TnewM2 saturating-decremented: 0 stays 0, n becomes n-1.
- Latency: one cycle from the M inputs to the W outputs. All outputs are combinational from the W register only; there is no M-to-W combinational path.
- RegWriteW = stored RegWrite AND (stored Awrite != 0). A write to $0 is never asserted.
- AwriteW: the stored Awrite when RegWriteW=1, else 0.
- Load extension, little-endian, with a = stored ALUout[1:0]:
  - byte = RD[8a+7 : 8a]
  - half = RD[31:16] if a[1] is 1, else RD[15:0]
  - lbu/lhu zero-extend; lb/lh sign-extend from bit 7 or bit 15.
  - lw passes the word; a is ignored, and no alignment check is made in this block.
- ResultW by stored MemtoReg: 00/11 stored ALUout; 01 extended load data; 10 stored PC_4+4 with 32-bit wrap (0xFFFFFFFC gives 0x00000000).
- flush and en==0 in the same cycle: flush wins and a bubble is inserted.
- Hold (en==0) keeps all outputs stable, including ResultW.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: on each posedge where reset is high and RegWriteW=1, the simulation prints "@%h: $%d <= %h" with PC_4W-4, AwriteW and ResultW. Nothing is printed for bubbles or for $0.
- Undefined: no print statements. Ports and logic are identical.

Test Plan:
- Reset: assert reset=0 mid-cycle after a capture -> all outputs 0 immediately; release, no capture until the next edge.
- Load extension: RDM=0x80FF7F01, Loadop lb, ALUout low bits 01, MemtoReg 01, Awrite 8 -> next cycle ResultW=0x0000007F, RegWriteW=1, AwriteW=8.
- Load extension, other types on the same RDM:
  - lb, addr 3 -> 0xFFFFFF80.
  - lbu, addr 3 -> 0x00000080.
  - lh, addr 2 -> 0xFFFF80FF.
  - lhu, addr 0 -> 0x00007F01.
- Jump-and-link: MemtoReg 10, PC_4M2=0x00003010, Awrite 31 -> ResultW=0x00003014. PC_4M2=0xFFFFFFFC -> 0x00000000.
- Tnew and $0 gating: TnewM2=2 -> TnewW=1; TnewM2=0 -> TnewW=0. RegWriteM2=1 with Awrite=0 -> RegWriteW=0.
- Stall and flush: en=0 for 3 cycles -> outputs frozen at the prior values. flush=1 with en=0 -> next cycle all outputs 0. Then en=1 -> a new capture one cycle later.
